// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control FSM, 0.1 s tick prescaler and lap display mux
// Define STOPWATCH_CTRL_LAP_EN to build the LAP state, lap registers and display mux.
module stopwatch_ctrl #(
  parameter int DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] q_ms,
  input  logic [7:0] q_ss,
  input  logic [7:0] q_mm,
  output logic       ci,
  output logic       count,
  output logic       stop,
  output logic       cnt_clr,
  output logic [3:0] disp_ms,
  output logic [7:0] disp_ss,
  output logic [7:0] disp_mm,
  output logic [2:0] state
);

  localparam int PSC_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    FULL  = 3'd4
  } state_t;

  state_t           st;
  state_t           st_next;
  logic [PSC_W-1:0] psc;
  logic             cnt_clr_next;
  logic             counting;
  logic             at_max;
`ifdef STOPWATCH_CTRL_LAP_EN
  logic             lap_load;
  logic [3:0]       lap_ms;
  logic [7:0]       lap_ss;
  logic [7:0]       lap_mm;
`endif

  assign at_max   = (q_mm == 8'h59) && (q_ss == 8'h59) && (q_ms == 4'd9);
  assign counting = (st == RUN) || (st == LAP);

  always_comb begin
    st_next      = st;
    cnt_clr_next = 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
    lap_load     = 1'b0;
`endif
    case (st)
      IDLE: begin
        if (btn_ss) st_next = RUN;
        else if (btn_lr) cnt_clr_next = 1'b1;
      end
      RUN: begin
        if (at_max) st_next = FULL;
        else if (btn_ss) st_next = PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
        else if (btn_lr) begin
          st_next  = LAP;
          lap_load = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_CTRL_LAP_EN
      LAP: begin
        if (at_max) st_next = FULL;
        else if (btn_ss) st_next = PAUSE;
        else if (btn_lr) st_next = RUN;
      end
`endif
      PAUSE: begin
        if (btn_ss) st_next = RUN;
        else if (btn_lr) begin
          st_next      = IDLE;
          cnt_clr_next = 1'b1;
        end
      end
      FULL: begin
        if (btn_lr) begin
          st_next      = IDLE;
          cnt_clr_next = 1'b1;
        end
      end
      default: st_next = IDLE;
    endcase
  end

  // Prescaler holds its phase outside RUN/LAP so a resume loses no partial tick.
  always_ff @(posedge clk) begin
    if (clr) begin
      st      <= IDLE;
      psc     <= '0;
      cnt_clr <= 1'b0;
    end else begin
      st      <= st_next;
      cnt_clr <= cnt_clr_next;
      if (cnt_clr) psc <= '0;
      else if (counting) psc <= (psc == PSC_MAX) ? '0 : psc + 1'b1;
    end
  end

`ifdef STOPWATCH_CTRL_LAP_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      lap_ms <= '0;
      lap_ss <= '0;
      lap_mm <= '0;
    end else if (lap_load) begin
      lap_ms <= q_ms;
      lap_ss <= q_ss;
      lap_mm <= q_mm;
    end
  end

  always_comb begin
    disp_ms = q_ms;
    disp_ss = q_ss;
    disp_mm = q_mm;
    if (st == LAP) begin
      disp_ms = lap_ms;
      disp_ss = lap_ss;
      disp_mm = lap_mm;
    end
  end
`else
  assign disp_ms = q_ms;
  assign disp_ss = q_ss;
  assign disp_mm = q_mm;
`endif

  // Masking with at_max keeps the chain from ever passing 59:59.9.
  assign ci    = (psc == PSC_MAX) && counting && !at_max;
  assign count = counting;
  assign stop  = (st == PAUSE) || (st == FULL);
  assign state = st;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM and tick generator that sequences the stopwatch counter chain: tenths digit, then seconds (BCD 00–59), then minutes (BCD 00–59).
- Turns two pre-debounced single-cycle button pulses into the counter's `ci`, `count`, `stop` and clear controls.
- Generates the 0.1 s tick from the system clock and saturates the count at 59:59.9.
- Supplies the display with either the live count or a frozen lap value.
- Sits between the button conditioning logic and the counter/display path.

## Interface
- `DIV`, default 5_000_000: system clock cycles per 0.1 s tick. Must be ≥ 2. The prescaler is `$clog2(DIV)` bits wide.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `btn_ss`  in  1  start/stop request. Single-cycle pulse.
- `btn_lr`  in  1  lap/reset request. Single-cycle pulse.
- `q_ms`  in  4  live tenths digit from the counter chain, binary 0–9.
- `q_ss`  in  8  live seconds from the counter chain, BCD.
- `q_mm`  in  8  live minutes from the counter chain, BCD.
- `ci`  out  1  tick to the counter chain `ci`.
- `count`  out  1  count enable.
- `stop`  out  1  stop hold.
- `cnt_clr`  out  1  one-cycle clear pulse, ORed with `clr` externally into the counter chain's clear.
- `disp_ms`  out  4  display value, tenths.
- `disp_ss`  out  8  display value, seconds.
- `disp_mm`  out  8  display value, minutes.
- `state`  out  3  current FSM state, for LEDs and debug.

## Operation
- States: IDLE=3'd0, RUN=3'd1, PAUSE=3'd2, LAP=3'd3, FULL=3'd4. Moore outputs are decoded from the state register.
- `at_max` is combinational and is 1 when `q_mm`==8'h59 && `q_ss`==8'h59 && `q_ms`==4'd9.
- Transitions:
  - IDLE: `btn_ss` → RUN. `btn_lr` → stay in IDLE and pulse `cnt_clr`.
  - RUN: `btn_ss` → PAUSE. `btn_lr` → LAP and capture `q_*` into the lap registers. `at_max` → FULL.
  - LAP: `btn_ss` → PAUSE. `btn_lr` → RUN, releasing the display. `at_max` → FULL.
  - PAUSE: `btn_ss` → RUN. `btn_lr` → IDLE and pulse `cnt_clr`.
  - FULL: `btn_lr` → IDLE and pulse `cnt_clr`. `btn_ss` is ignored.
- Priority:
  - `at_max` beats both buttons in RUN and LAP.
  - `btn_ss` beats `btn_lr` when both are asserted in the same cycle; `btn_lr` is dropped.
- Outputs:
  - `count` = 1 in RUN and LAP.
  - `stop` = 1 in PAUSE and FULL.
  - IDLE has `count`=0 and `stop`=0.
- Prescaler:
  - Advances only in RUN and LAP, and is held in every other state.
  - Wraps from DIV-1 to 0.
  - Cleared on `clr` and whenever `cnt_clr` is asserted.
- `ci` = (prescaler==DIV-1) && (state is RUN or LAP) && !`at_max`. It is combinational from registers and inputs, so the counter never advances past 59:59.9.
- Display: `disp_*` = lap registers in LAP, otherwise the live `q_*`. This is a combinational mux.
- Reset (`clr`): state=IDLE, prescaler=0, lap registers=0, `cnt_clr`=0. As a result `count`=0, `stop`=0 and `ci`=0, and `disp_*` shows the live `q_*`.
- `clr` in mid-operation overrides any button in the same cycle.

## Timing
- A button pulse sampled at edge N changes the state at edge N. The new `count`/`stop` values are visible from cycle N+1.
- `cnt_clr` is registered and is high for exactly cycle N+1 after the `btn_lr` edge. The counter clears at edge N+1.
- The first `ci` after IDLE→RUN occurs DIV cycles after the state change. `ci` repeats every DIV cycles while counting.
- PAUSE→RUN resumes with the prescaler phase preserved. No partial tick is lost.
- Lap capture happens on the same edge as the RUN→LAP or LAP-capture transition. The frozen value is visible from the next cycle.
- Saturation sequence:
  - The counter reaches 59:59.9 at some edge.
  - `at_max` is high in the following cycle, which masks `ci` combinationally.
  - The FSM enters FULL on the next edge.

## Configuration
- `STOPWATCH_CTRL_LAP_EN` defined:
  - The LAP state, the lap registers (20 bits) and the display mux are compiled in.
  - Behaviour is as described above.
- `STOPWATCH_CTRL_LAP_EN` undefined:
  - No lap registers are built, and `disp_*` = `q_*` always.
  - `btn_lr` in RUN is ignored, and the LAP encoding is unreachable.
  - All other transitions are unchanged.

## Test plan
- DIV=4, `clr` then `btn_ss` → `state`=1, `count`=1. `ci` pulses every 4 cycles, and the chain reads 00:01.0 after 40 cycles.
- RUN, `btn_ss` at cycle 10, then `btn_ss` at cycle 30 → no `ci` during PAUSE (`stop`=1). The first `ci` after resume arrives after the remaining prescaler count only.
- RUN at 00:03.4, `btn_lr` → `disp_*`=00:03.4 frozen while `q_*` keeps advancing. A second `btn_lr` returns the display to live. Without `STOPWATCH_CTRL_LAP_EN`, `btn_lr` has no effect.
- Preload the chain to 59:59.8 in RUN → one more `ci` reaches 59:59.9, then `ci` stays 0 and `state`=4. `btn_ss` is ignored, and `btn_lr` produces a `cnt_clr` pulse and `state`=0.
- RUN with `btn_ss` and `btn_lr` in the same cycle → PAUSE and no lap capture. PAUSE with `btn_lr` → `cnt_clr` high for 1 cycle and `state`=0.
- LAP with `clr` and `btn_ss` in the same cycle → `state`=0, lap registers=0, `count`=0, `cnt_clr`=0.
